exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning exception entry PC.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 valid_i  in  1  MEM-stage instruction valid.
REQ-005 stall_i  in  1  MEM stage stalled; no new detection this cycle.
REQ-006 pc_i  in  32  MEM-stage instruction PC.
REQ-007 is_in_delayslot_i  in  1  instruction is in a branch delay slot.
REQ-008 exc_flags_i  in  6  {eret, trap, break, syscall, ri, adel_fetch}, bit 0 = adel_fetch.
REQ-009 ov_i  in  1  arithmetic overflow.
REQ-010 mem_addr_i  in  32  load/store effective address.
REQ-011 mem_op_i  in  2  {we, re}.
REQ-012 mem_size_i  in  2  0 byte, 1 half, 2 word.
REQ-013 mem_busy_i  in  1  bus transaction outstanding.
REQ-014 int_i  in  6  external hardware interrupts.
REQ-015 cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 values.
REQ-016 wb_cp0_i  in  38  {we, waddr[4:0], data[31:0]} CP0 write in flight in WB.
REQ-017 excepttype_o  out  32  code to CP0: 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, d Tr, e eret, 0 none.
REQ-018 current_inst_addr_o / bad_addr_o  out  32 each  faulting PC / faulting address.
REQ-019 is_in_delayslot_o  out  1  delay-slot flag of the faulting instruction.
REQ-020 flush_o  out  1  pipeline flush pulse.
REQ-021 new_pc_o  out  32  redirect target, valid while flush_o=1.
REQ-022 mem_cancel_o  out  1  suppress the MEM-stage store/load, combinational.

Function
REQ-023 Status, cause and EPC SHALL be forwarded from wb_cp0_i when we=1 and waddr matches (12/13/14) before use.
REQ-024 Interrupt pending SHALL be ((cause[15:10] with int_i substituted, cause[9:8]) & status[15:8]) != 0, status[0]=1 and status[1]=0.
REQ-025 Data misalignment: half with addr[0]=1, word with addr[1:0]!=0; re gives AdEL, we gives AdES.
REQ-026 Priority SHALL be int > adel_fetch > ri > ov > syscall > break > trap > data AdEL/AdES > eret.
REQ-027 bad_addr SHALL be pc_i for adel_fetch and mem_addr_i for data faults, else 0.
REQ-028 Detection SHALL occur only when valid_i=1 and stall_i=0; mem_cancel_o=1 whenever a detected cause is non-none.
REQ-029 FSM IDLE: detection captures type, PC, delay-slot flag and bad_addr; go DRAIN if mem_busy_i=1, else FLUSH.
REQ-030 DRAIN: hold captured values, ignore new detections, go FLUSH when mem_busy_i=0.
REQ-031 FLUSH (exactly one cycle): flush_o=1, registered outputs present the captured values, then go IDLE.
REQ-032 new_pc_o SHALL be forwarded EPC for eret, else EXC_VECTOR.
REQ-033 excepttype_o SHALL be non-zero only in FLUSH, so CP0 commits exactly once per exception.
REQ-034 Outside FLUSH, all registered outputs SHALL be 0.

Reset
REQ-035 On rst=0, FSM SHALL be IDLE, all outputs 0, and captured registers cleared, regardless of state (including mid-DRAIN).

Configuration
REQ-036 With EXC_INT_SYNC_EN defined, int_i SHALL pass through a two-flop synchronizer (reset to 0), adding 2 cycles interrupt latency; without it, int_i is used directly.

Structure
REQ-037 Exception codes, CP0 register addresses and the FSM state encoding SHALL live in the shared defines package.
REQ-038 Priority encoding SHALL be one combinational sub-module, exc_prio_enc.

Verification
REQ-039 syscall at pc=0x80000100, mem_busy_i=0 -> next cycle flush_o=1, excepttype_o=8, new_pc_o=0xBFC00380, for 1 cycle.
REQ-040 Word load to addr 0x1002 with ov_i=1 -> excepttype_o=0xc, bad_addr_o=0; repeat with ov_i=0 -> 4, bad_addr_o=0x1002.
REQ-041 Store fault with mem_busy_i high for 3 cycles -> mem_cancel_o=1 at detection, flush_o 1 cycle after busy falls, excepttype_o=5.
REQ-042 eret with wb_cp0_i writing EPC=0x80001000 the same cycle -> new_pc_o=0x80001000, excepttype_o=0xe.
REQ-043 int_i[0]=1, status=0x00000401 -> excepttype_o=1 (+2 cycles with EXC_INT_SYNC_EN); status[1]=1 -> no exception.
REQ-044 rst asserted in DRAIN -> outputs 0 immediately; after release, no flush pulse.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// ============================================================================
// exception_ctrl_pkg : exception codes, CP0 register addresses, FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package exception_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Bit positions inside exc_flags_i
    localparam int EXF_ADEL_FETCH = 0;
    localparam int EXF_RI         = 1;
    localparam int EXF_SYSCALL    = 2;
    localparam int EXF_BREAK      = 3;
    localparam int EXF_TRAP       = 4;
    localparam int EXF_ERET       = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } exc_state_e;

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ============================================================================
// exc_prio_enc : combinational exception priority encoder and bad-address mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  logic        int_pend_i,
    input  logic [5:0]  exc_flags_i,
    input  logic        ov_i,
    input  logic        data_adel_i,
    input  logic        data_ades_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mem_addr_i,
    output logic [31:0] exc_type_o,
    output logic [31:0] bad_addr_o
);

    always_comb begin
        exc_type_o = EXC_NONE;
        bad_addr_o = 32'h0;
        if (int_pend_i) begin
            exc_type_o = EXC_INT;
        end else if (exc_flags_i[EXF_ADEL_FETCH]) begin
            exc_type_o = EXC_ADEL;
            bad_addr_o = pc_i;
        end else if (exc_flags_i[EXF_RI]) begin
            exc_type_o = EXC_RI;
        end else if (ov_i) begin
            exc_type_o = EXC_OV;
        end else if (exc_flags_i[EXF_SYSCALL]) begin
            exc_type_o = EXC_SYS;
        end else if (exc_flags_i[EXF_BREAK]) begin
            exc_type_o = EXC_BP;
        end else if (exc_flags_i[EXF_TRAP]) begin
            exc_type_o = EXC_TR;
        end else if (data_adel_i) begin
            exc_type_o = EXC_ADEL;
            bad_addr_o = mem_addr_i;
        end else if (data_ades_i) begin
            exc_type_o = EXC_ADES;
            bad_addr_o = mem_addr_i;
        end else if (exc_flags_i[EXF_ERET]) begin
            exc_type_o = EXC_ERET;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// exception_ctrl : MEM-stage exception detection, bus drain and flush sequencing
// Optional macro EXC_INT_SYNC_EN adds a two-flop synchronizer on int_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [5:0]  exc_flags_i,
    input  logic        ov_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_op_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_busy_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [37:0] wb_cp0_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] bad_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        mem_cancel_o
);

    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic [5:0]  int_eff;
    logic        int_pend, misalign, data_adel, data_ades, det;
    logic [31:0] exc_type, exc_bad;

    assign wb_we   = wb_cp0_i[37];
    assign wb_addr = wb_cp0_i[36:32];
    assign wb_data = wb_cp0_i[31:0];

    // A CP0 write still in WB is newer than the values the register file shows
    assign status_fwd = (wb_we && wb_addr == CP0_STATUS) ? wb_data : cp0_status_i;
    assign cause_fwd  = (wb_we && wb_addr == CP0_CAUSE)  ? wb_data : cp0_cause_i;
    assign epc_fwd    = (wb_we && wb_addr == CP0_EPC)    ? wb_data : cp0_epc_i;

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_fwd[31:16], status_fwd[7:2],
                               cause_fwd[31:10], cause_fwd[7:0]};

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_s1_d, int_s1_q, int_s2_d, int_s2_q;
    assign int_s1_d = int_i;
    assign int_s2_d = int_s1_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_s1_q <= 6'h0;
            int_s2_q <= 6'h0;
        end else begin
            int_s1_q <= int_s1_d;
            int_s2_q <= int_s2_d;
        end
    end
    assign int_eff = int_s2_q;
`else
    assign int_eff = int_i;
`endif

    assign int_pend = (|({int_eff, cause_fwd[9:8]} & status_fwd[15:8]))
                      & status_fwd[0] & ~status_fwd[1];

    always_comb begin
        misalign = 1'b0;
        case (mem_size_i)
            2'd1:    misalign = mem_addr_i[0];
            2'd2:    misalign = |mem_addr_i[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign data_adel = mem_op_i[0] & misalign;
    assign data_ades = mem_op_i[1] & misalign;

    exc_prio_enc u_prio (
        .int_pend_i  (int_pend),
        .exc_flags_i (exc_flags_i),
        .ov_i        (ov_i),
        .data_adel_i (data_adel),
        .data_ades_i (data_ades),
        .pc_i        (pc_i),
        .mem_addr_i  (mem_addr_i),
        .exc_type_o  (exc_type),
        .bad_addr_o  (exc_bad)
    );

    assign det          = valid_i & ~stall_i;
    assign mem_cancel_o = det & (exc_type != EXC_NONE);

    exc_state_e  state_d, state_q;
    logic [31:0] type_d, type_q, pc_d, pc_q, bad_d, bad_q, npc_d, npc_q;
    logic        ds_d, ds_q;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        npc_d   = npc_q;
        ds_d    = ds_q;
        case (state_q)
            ST_IDLE: begin
                if (det && exc_type != EXC_NONE) begin
                    type_d  = exc_type;
                    pc_d    = pc_i;
                    bad_d   = exc_bad;
                    ds_d    = is_in_delayslot_i;
                    npc_d   = (exc_type == EXC_ERET) ? epc_fwd : EXC_VECTOR;
                    state_d = mem_busy_i ? ST_DRAIN : ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                type_d  = 32'h0;
                pc_d    = 32'h0;
                bad_d   = 32'h0;
                npc_d   = 32'h0;
                ds_d    = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            type_q  <= 32'h0;
            pc_q    <= 32'h0;
            bad_q   <= 32'h0;
            npc_q   <= 32'h0;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            npc_q   <= npc_d;
            ds_q    <= ds_d;
        end
    end

    // Gating by the state flop keeps every output zero outside the flush cycle
    assign flush_o             = (state_q == ST_FLUSH);
    assign excepttype_o        = flush_o ? type_q : 32'h0;
    assign current_inst_addr_o = flush_o ? pc_q   : 32'h0;
    assign bad_addr_o          = flush_o ? bad_q  : 32'h0;
    assign new_pc_o            = flush_o ? npc_q  : 32'h0;
    assign is_in_delayslot_o   = flush_o & ds_q;

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// ============================================================================
// tb_exception_ctrl : randomized scoreboard bench for exception_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0, stall_i = 1'b0, is_in_delayslot_i = 1'b0;
    logic [31:0] pc_i = '0, mem_addr_i = '0;
    logic [5:0]  exc_flags_i = '0, int_i = '0;
    logic        ov_i = 1'b0, mem_busy_i = 1'b0;
    logic [1:0]  mem_op_i = '0, mem_size_i = '0;
    logic [31:0] cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0;
    logic [37:0] wb_cp0_i = '0;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, mem_cancel_o;

    exception_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
        .is_in_delayslot_i(is_in_delayslot_i), .exc_flags_i(exc_flags_i), .ov_i(ov_i),
        .mem_addr_i(mem_addr_i), .mem_op_i(mem_op_i), .mem_size_i(mem_size_i),
        .mem_busy_i(mem_busy_i), .int_i(int_i), .cp0_status_i(cp0_status_i),
        .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .wb_cp0_i(wb_cp0_i),
        .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
        .bad_addr_o(bad_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .flush_o(flush_o), .new_pc_o(new_pc_o), .mem_cancel_o(mem_cancel_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] typ;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   due = -1;
    bit   outstanding = 1'b0;
    logic [5:0] hist0 = '0, hist1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Interrupt lines the DUT will act on at the coming edge
    function automatic logic [5:0] eff_irq();
`ifdef EXC_INT_SYNC_EN
        return hist1;
`else
        return int_i;
`endif
    endfunction

    // Reference: exception cause from the current inputs, straight from the rules
    task automatic ref_eval(input logic [5:0] irq, output logic [31:0] typ,
                            output logic [31:0] bad, output logic [31:0] npc);
        logic [31:0] st, ca, ep;
        logic        pend, mis;
        st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
        if (wb_cp0_i[37] && wb_cp0_i[36:32] == 5'd12) st = wb_cp0_i[31:0];
        if (wb_cp0_i[37] && wb_cp0_i[36:32] == 5'd13) ca = wb_cp0_i[31:0];
        if (wb_cp0_i[37] && wb_cp0_i[36:32] == 5'd14) ep = wb_cp0_i[31:0];
        pend = ((({irq, ca[9:8]}) & st[15:8]) != 8'h0) && st[0] && !st[1];
        mis  = (mem_size_i == 2'd1 && mem_addr_i[0]) ||
               (mem_size_i == 2'd2 && mem_addr_i[1:0] != 2'b00);
        bad = 32'h0;
        if (pend)                       typ = 32'h1;
        else if (exc_flags_i[0])        begin typ = 32'h4; bad = pc_i; end
        else if (exc_flags_i[1])        typ = 32'ha;
        else if (ov_i)                  typ = 32'hc;
        else if (exc_flags_i[2])        typ = 32'h8;
        else if (exc_flags_i[3])        typ = 32'h9;
        else if (exc_flags_i[4])        typ = 32'hd;
        else if (mis && mem_op_i[0])    begin typ = 32'h4; bad = mem_addr_i; end
        else if (mis && mem_op_i[1])    begin typ = 32'h5; bad = mem_addr_i; end
        else if (exc_flags_i[5])        typ = 32'he;
        else                            typ = 32'h0;
        npc = (typ == 32'he) ? ep : VEC;
    endtask

    // One exception in flight at a time; it flushes the cycle after the bus is idle
    task automatic model_edge();
        logic [31:0] typ, bad, npc;
        cyc++;
        ref_eval(eff_irq(), typ, bad, npc);
        hist1 = hist0;
        hist0 = int_i;
        if (outstanding) begin
            if (due >= 0 && cyc == due + 1) outstanding = 1'b0;
            else if (due < 0 && !mem_busy_i) due = cyc;
        end else if (valid_i && !stall_i && typ != 32'h0) begin
            exp_q.push_back('{typ: typ, pc: pc_i, ds: is_in_delayslot_i, bad: bad, npc: npc});
            outstanding = 1'b1;
            due = mem_busy_i ? -1 : cyc;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; stall_i = 0; exc_flags_i = 0; ov_i = 0; mem_op_i = 0;
        mem_size_i = 0; mem_addr_i = 0; int_i = 0; wb_cp0_i = 0; pc_i = 0;
        is_in_delayslot_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 1'b0;
        due = -1;
        hist0 = '0;
        hist1 = '0;
    endtask

    // Monitor: pops the scoreboard whenever a flush is presented
    always @(negedge clk) begin
        logic [31:0] typ, bad, npc;
        logic        exp_flush;
        exp_t        e;
        exp_flush = rst && outstanding && (due == cyc);
        chk("flush_o", {31'h0, flush_o}, {31'h0, exp_flush});
        if (flush_o && exp_flush) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("excepttype_o", excepttype_o, e.typ);
                chk("current_inst_addr_o", current_inst_addr_o, e.pc);
                chk("bad_addr_o", bad_addr_o, e.bad);
                chk("is_in_delayslot_o", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
                chk("new_pc_o", new_pc_o, e.npc);
            end
        end else if (!flush_o) begin
            chk("idle_excepttype", excepttype_o, 32'h0);
            chk("idle_outputs", current_inst_addr_o | bad_addr_o | new_pc_o |
                {31'h0, is_in_delayslot_o}, 32'h0);
        end
        ref_eval(eff_irq(), typ, bad, npc);
        chk("mem_cancel_o", {31'h0, mem_cancel_o},
            {31'h0, (valid_i && !stall_i && typ != 32'h0)});
    end

    initial begin
        logic [31:0] r;
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // syscall, bus idle
        valid_i = 1; pc_i = 32'h80000100; exc_flags_i = 6'b000100;
        cycle(); idle_inputs(); repeat (3) cycle();

        // misaligned word load with overflow, then without
        valid_i = 1; pc_i = 32'h80000200; mem_op_i = 2'b01; mem_size_i = 2'd2;
        mem_addr_i = 32'h1002; ov_i = 1;
        cycle(); idle_inputs(); repeat (3) cycle();
        valid_i = 1; pc_i = 32'h80000204; mem_op_i = 2'b01; mem_size_i = 2'd2;
        mem_addr_i = 32'h1002; ov_i = 0;
        cycle(); idle_inputs(); repeat (3) cycle();

        // misaligned store while the bus is busy for three cycles
        valid_i = 1; pc_i = 32'h80000300; mem_op_i = 2'b10; mem_size_i = 2'd1;
        mem_addr_i = 32'h2001; mem_busy_i = 1; is_in_delayslot_i = 1;
        cycle(); idle_inputs(); repeat (2) cycle();
        mem_busy_i = 0; repeat (3) cycle();

        // eret with EPC written from WB in the same cycle
        valid_i = 1; pc_i = 32'h80000400; exc_flags_i = 6'b100000;
        cp0_epc_i = 32'h12345678; wb_cp0_i = {1'b1, 5'd14, 32'h80001000};
        cycle(); idle_inputs(); repeat (3) cycle();

        // interrupt enabled, then masked by EXL
        valid_i = 1; int_i = 6'h01; cp0_status_i = 32'h00000401; pc_i = 32'h80000500;
        repeat (4) cycle();
        idle_inputs(); repeat (4) cycle();
        valid_i = 1; int_i = 6'h01; cp0_status_i = 32'h00000403; pc_i = 32'h80000600;
        repeat (4) cycle();
        idle_inputs(); repeat (4) cycle();

        // reset while draining
        valid_i = 1; pc_i = 32'h80000700; mem_op_i = 2'b10; mem_size_i = 2'd2;
        mem_addr_i = 32'h3003; mem_busy_i = 1;
        cycle(); idle_inputs(); cycle();
        #2 rst = 1'b0;
        model_reset();
        #1 chk("reset_flush", {31'h0, flush_o}, 32'h0);
        chk("reset_excepttype", excepttype_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; mem_busy_i = 0;
        repeat (4) cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom; valid_i = (r[3:0] < 4'd11); stall_i = (r[6:4] == 3'd0);
            is_in_delayslot_i = r[7]; mem_busy_i = (r[9:8] == 2'b00);
            ov_i = (r[13:10] == 4'd0); mem_op_i = r[15:14]; mem_size_i = r[17:16];
            exc_flags_i = (r[19:18] == 2'b00) ? (6'h1 << r[22:20]) : 6'h0;
            int_i = (r[26:23] == 4'd0) ? r[31:26] : 6'h0;
            pc_i = $urandom; mem_addr_i = $urandom;
            r = $urandom; cp0_status_i = r;
            cp0_status_i[0] = (r[17:16] != 2'b00);
            cp0_status_i[1] = (r[19:18] == 2'b00);
            r = $urandom; cp0_cause_i = r;
            if (r[3:0] != 4'd0) cp0_cause_i[9:8] = 2'b00;
            cp0_epc_i = $urandom;
            r = $urandom;
            wb_cp0_i = {(r[1:0] == 2'b00), (r[3:2] == 2'b11) ? r[8:4] : (5'd12 + {3'b0, r[5:4] % 2'd3}), 32'h0};
            wb_cp0_i[31:0] = $urandom;
            cycle();
        end

        idle_inputs(); mem_busy_i = 0;
        for (int k = 0; k < 20 && outstanding; k++) cycle();
        repeat (2) cycle();
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
